// File: rtl/qpu_ifu_itcm_fetch_if.sv
// qpu_ifu_itcm_fetch_if: ICB read port between the IFU fetch unit and the ITCM controller
//  master (IFU): drives cmd_valid/addr/read/wdata/wmask and rsp_ready; samples cmd_ready, rsp_valid, rsp_rdata
//  slave (ITCM): the mirror image
interface qpu_ifu_itcm_fetch_if #(
   parameter int AW = 16,
   parameter int DW = 64
);
   logic          ifu_icb_cmd_valid;
   logic          ifu_icb_cmd_ready;
   logic [AW-1:0] ifu_icb_cmd_addr;
   logic          ifu_icb_cmd_read;
   logic [DW-1:0] ifu_icb_cmd_wdata;
   logic [DW/8-1:0] ifu_icb_cmd_wmask;
   logic          ifu_icb_rsp_valid;
   logic          ifu_icb_rsp_ready;
   logic [DW-1:0] ifu_icb_rsp_rdata;
   modport master (
      output ifu_icb_cmd_valid, ifu_icb_cmd_addr, ifu_icb_cmd_read, ifu_icb_cmd_wdata, ifu_icb_cmd_wmask,
      output ifu_icb_rsp_ready,
      input  ifu_icb_cmd_ready, ifu_icb_rsp_valid, ifu_icb_rsp_rdata
   );
   modport slave (
      input  ifu_icb_cmd_valid, ifu_icb_cmd_addr, ifu_icb_cmd_read, ifu_icb_cmd_wdata, ifu_icb_cmd_wmask,
      input  ifu_icb_rsp_ready,
      output ifu_icb_cmd_ready, ifu_icb_rsp_valid, ifu_icb_rsp_rdata
   );
endinterface

// File: rtl/qpu_ifu_itcm_fetch.sv
// qpu_ifu_itcm_fetch: IFU-side ICB initiator that walks a fetch PC, issues single-outstanding ITCM reads and queues words for the decoder
//  clk, rst                   : clock, asynchronous active-high reset
//  fetch_en                   : permission to issue new read commands
//  redirect_valid/redirect_pc : load new PC (word aligned), flush queue, discard in-flight response
//  icb (master)               : ICB read command/response channel to the ITCM controller
//  instr_valid/ready/data/pc  : 2-entry fetch queue head towards the decoder
//  ifu_busy                   : command pending or outstanding, or queue non-empty
module qpu_ifu_itcm_fetch #(
   parameter int AW = 16,
   parameter int DW = 64,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_en,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   qpu_ifu_itcm_fetch_if.master icb,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [DW-1:0] instr_data,
   output logic [AW-1:0] instr_pc,
   output logic          ifu_busy
);
   localparam logic [AW-1:0] STEP = AW'(DW/8);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t           state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic             drop_q, drop_d;
   logic [1:0]       cnt_q, cnt_d, cnt_p;
   logic [DW+AW-1:0] e0_q, e0_d, e1_q, e1_d, e0_p, word;
   logic             cmd_valid_q, cmd_valid_d, rsp_ready_q, rsp_ready_d, busy_q, busy_d;
   logic             pop, rsp_hs, push, go;
   always_comb begin
      pop    = (cnt_q != 2'd0) & instr_ready;
      rsp_hs = (state_q == WAIT) & icb.ifu_icb_rsp_valid;
      // redirect beats a genuine response; stale responses are swallowed while drop is set
      push   = rsp_hs & ~drop_q & ~redirect_valid;
      word   = {icb.ifu_icb_rsp_rdata, pc_q};
      cnt_p  = cnt_q - {1'b0, pop};
      e0_p   = pop ? e1_q : e0_q;
      e0_d   = (push & (cnt_p == 2'd0)) ? word : e0_p;
      e1_d   = (push & (cnt_p != 2'd0)) ? word : e1_q;
      cnt_d  = redirect_valid ? 2'd0 : cnt_p + {1'b0, push};
      pc_d   = redirect_valid ? (redirect_pc & ~(STEP - 1'b1)) : push ? pc_q + STEP : pc_q;
      // room is judged after this cycle's push/pop/flush; nothing is outstanding when deciding
      go     = fetch_en & (cnt_d < 2'd2);
      state_d = (state_q == IDLE) ? (go ? REQ : IDLE) :
                (state_q == REQ)  ? (icb.ifu_icb_cmd_ready ? WAIT : REQ) :
                rsp_hs ? (go ? REQ : IDLE) : WAIT;
      // a redirect that catches a command already accepted marks its response as stale
      drop_d = rsp_hs ? 1'b0 :
               drop_q | (redirect_valid & (((state_q == REQ) & icb.ifu_icb_cmd_ready) | (state_q == WAIT)));
      cmd_valid_d = state_d == REQ;
      rsp_ready_d = state_d == WAIT;
      busy_d      = (state_d != IDLE) | (cnt_d != 2'd0);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         cnt_q       <= 2'd0;
         e0_q        <= '0;
         e1_q        <= '0;
         cmd_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         cnt_q       <= cnt_d;
         e0_q        <= e0_d;
         e1_q        <= e1_d;
         cmd_valid_q <= cmd_valid_d;
         rsp_ready_q <= rsp_ready_d;
         busy_q      <= busy_d;
      end
   assign icb.ifu_icb_cmd_valid = cmd_valid_q;
   assign icb.ifu_icb_cmd_addr  = pc_q;
   assign icb.ifu_icb_cmd_read  = 1'b1;
   assign icb.ifu_icb_cmd_wdata = '0;
   assign icb.ifu_icb_cmd_wmask = '0;
   assign icb.ifu_icb_rsp_ready = rsp_ready_q;
   assign instr_valid = cnt_q != 2'd0;
   assign instr_data  = e0_q[AW +: DW];
   assign instr_pc    = e0_q[AW-1:0];
   assign ifu_busy    = busy_q;
endmodule

// File: tb/tb_qpu_ifu_itcm_fetch.sv
// tb_qpu_ifu_itcm_fetch: directed bench for the ITCM fetch unit with a one-cycle ITCM responder
module tb_qpu_ifu_itcm_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        instr_valid, ifu_busy;
   logic [63:0] instr_data;
   logic [15:0] instr_pc;
   logic        hold = 1'b0;
   logic        pend;
   logic [15:0] paddr;
   logic [15:0] cmd_log[$];
   int          n_vec = 0, n_err = 0;
   qpu_ifu_itcm_fetch_if #(.AW(16), .DW(64)) icb ();
   qpu_ifu_itcm_fetch #(.AW(16), .DW(64), .RESET_PC(16'h0)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .icb(icb.master), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc), .ifu_busy(ifu_busy)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] f(input logic [15:0] a);
      return {~a, a ^ 16'h5a5a, 16'hc0de, a};
   endfunction
   always @(posedge clk or posedge rst)
      if (rst) pend <= 1'b0;
      else if (icb.ifu_icb_cmd_valid & icb.ifu_icb_cmd_ready) begin
         pend  <= 1'b1;
         paddr <= icb.ifu_icb_cmd_addr;
      end else if (icb.ifu_icb_rsp_valid & icb.ifu_icb_rsp_ready) pend <= 1'b0;
   assign icb.ifu_icb_rsp_valid = pend & ~hold;
   assign icb.ifu_icb_rsp_rdata = f(paddr);
   always @(posedge clk)
      if (!rst & icb.ifu_icb_cmd_valid & icb.ifu_icb_cmd_ready) cmd_log.push_back(icb.ifu_icb_cmd_addr);
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset(input logic fe, input logic ir, input logic cr);
      @(negedge clk);
      rst = 1'b1;
      hold = 1'b0;
      redirect_valid = 1'b0;
      fetch_en = fe;
      instr_ready = ir;
      icb.ifu_icb_cmd_ready = cr;
      tick(2);
      cmd_log.delete();
      rst = 1'b0;
   endtask
   initial begin
      icb.ifu_icb_cmd_ready = 1'b1;
      tick(2);
      chk("rst_cmd_valid", icb.ifu_icb_cmd_valid, 0);
      chk("rst_rsp_ready", icb.ifu_icb_rsp_ready, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_busy", ifu_busy, 0);
      chk("rst_instr_data", instr_data, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("const_read", icb.ifu_icb_cmd_read, 1);
      chk("const_wdata", icb.ifu_icb_cmd_wdata, 0);
      chk("const_wmask", icb.ifu_icb_cmd_wmask, 0);
      // 1: streaming fetch
      do_reset(1, 1, 1);
      tick(1);
      chk("t1_cmd_valid", icb.ifu_icb_cmd_valid, 1);
      chk("t1_addr0", icb.ifu_icb_cmd_addr, 16'h0);
      tick(1);
      chk("t1_rsp_ready", icb.ifu_icb_rsp_ready, 1);
      chk("t1_not_yet_valid", instr_valid, 0);
      tick(1);
      chk("t1_first_valid", instr_valid, 1);
      chk("t1_first_pc", instr_pc, 16'h0);
      chk("t1_first_data", instr_data, f(16'h0));
      tick(2);
      chk("t1_second_pc", instr_pc, 16'h8);
      chk("t1_second_data", instr_data, f(16'h8));
      tick(5);
      chk("t1_ncmd", cmd_log.size(), 5);
      for (int i = 0; i < 5; i++) chk("t1_cmd_addr", cmd_log[i], 64'(8 * i));
      // 2: backpressure fills the queue, one pop re-opens fetching
      do_reset(1, 0, 1);
      tick(10);
      chk("t2_ncmd", cmd_log.size(), 2);
      chk("t2_cmd_valid", icb.ifu_icb_cmd_valid, 0);
      chk("t2_valid", instr_valid, 1);
      chk("t2_head_pc", instr_pc, 16'h0);
      chk("t2_busy", ifu_busy, 1);
      instr_ready = 1'b1;
      tick(1);
      instr_ready = 1'b0;
      chk("t2_refetch_valid", icb.ifu_icb_cmd_valid, 1);
      chk("t2_refetch_addr", icb.ifu_icb_cmd_addr, 16'h10);
      chk("t2_head_after_pop", instr_pc, 16'h8);
      // 3: redirect while waiting on a delayed response flushes the queue
      do_reset(1, 0, 1);
      tick(3);
      hold = 1'b1;
      tick(1);
      chk("t3_head_before", instr_pc, 16'h0);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0103;
      tick(1);
      redirect_valid = 1'b0;
      hold = 1'b0;
      chk("t3_flushed", instr_valid, 0);
      chk("t3_still_wait", icb.ifu_icb_rsp_ready, 1);
      tick(1);
      chk("t3_drop_no_push", instr_valid, 0);
      chk("t3_cmd_valid", icb.ifu_icb_cmd_valid, 1);
      chk("t3_cmd_addr", icb.ifu_icb_cmd_addr, 16'h0100);
      tick(2);
      chk("t3_valid", instr_valid, 1);
      chk("t3_pc", instr_pc, 16'h0100);
      chk("t3_data", instr_data, f(16'h0100));
      // 4a: redirect in the same cycle as the response
      do_reset(1, 1, 1);
      tick(2);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0200;
      tick(1);
      redirect_valid = 1'b0;
      chk("t4a_no_stale", instr_valid, 0);
      chk("t4a_cmd_addr", icb.ifu_icb_cmd_addr, 16'h0200);
      chk("t4a_cmd_valid", icb.ifu_icb_cmd_valid, 1);
      tick(2);
      chk("t4a_pc", instr_pc, 16'h0200);
      chk("t4a_valid", instr_valid, 1);
      // 4b: redirect in the same cycle as the command handshake
      do_reset(1, 1, 1);
      tick(1);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0305;
      tick(1);
      redirect_valid = 1'b0;
      tick(1);
      chk("t4b_no_stale", instr_valid, 0);
      chk("t4b_cmd_addr", icb.ifu_icb_cmd_addr, 16'h0300);
      tick(2);
      chk("t4b_pc", instr_pc, 16'h0300);
      chk("t4b_data", instr_data, f(16'h0300));
      chk("t4b_cmd1", cmd_log[1], 16'h0300);
      // 5: command stalled by the ITCM for three cycles
      do_reset(1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("t5_hold_valid", icb.ifu_icb_cmd_valid, 1);
         chk("t5_hold_addr", icb.ifu_icb_cmd_addr, 16'h0);
      end
      icb.ifu_icb_cmd_ready = 1'b1;
      tick(1);
      chk("t5_in_wait", icb.ifu_icb_cmd_valid, 0);
      chk("t5_ncmd", cmd_log.size(), 1);
      tick(1);
      chk("t5_pc", instr_pc, 16'h0);
      chk("t5_valid", instr_valid, 1);
      // 6: pc wrap, then fetch_en dropped mid-WAIT
      do_reset(1, 1, 1);
      redirect_valid = 1'b1;
      redirect_pc = 16'hfff8;
      tick(1);
      redirect_valid = 1'b0;
      chk("t6_addr_top", icb.ifu_icb_cmd_addr, 16'hfff8);
      tick(2);
      chk("t6_top_pc", instr_pc, 16'hfff8);
      chk("t6_wrap_addr", icb.ifu_icb_cmd_addr, 16'h0);
      tick(1);
      fetch_en = 1'b0;
      tick(1);
      chk("t6_idle", icb.ifu_icb_cmd_valid, 0);
      chk("t6_queued", instr_valid, 1);
      chk("t6_queued_pc", instr_pc, 16'h0);
      chk("t6_busy", ifu_busy, 1);
      tick(1);
      chk("t6_drained", instr_valid, 0);
      chk("t6_not_busy", ifu_busy, 0);
      tick(3);
      chk("t6_no_new_cmd", cmd_log.size(), 2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
